// File: rtl/fetch_pkg.sv
// Shared widths, reset constants and state encoding for the fetch stage.
package fetch_pkg;

   localparam int unsigned PC_W    = 8;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned CNT_W   = 16;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: async reset, load has priority over increment,
// wraps modulo 2^PC_W.
module pc_counter
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc,
   input  logic            load,
   input  logic [PC_W-1:0] load_val,
   output logic [PC_W-1:0] pc
);

   // PC update: reset, then redirect load, then sequential increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       pc <= RESET_PC;
      else if (load) pc <= load_val;
      else if (inc)  pc <= pc + PC_W'(1);
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses an external combinational
// ROM and hands captured instructions to decode over a valid/ready handshake.
// Optional feature: define FETCH_COUNT_EN to enable the fetched-instruction
// counter; otherwise fetch_count is tied to zero.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_en,
   output logic [PC_W-1:0]    pc_out,
   input  logic [INSTR_W-1:0] rom_data,
   output logic [INSTR_W-1:0] ir_out,
   output logic [PC_W-1:0]    ir_pc,
   output logic               ir_valid,
   input  logic               ir_ready,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [CNT_W-1:0]   fetch_count
);

   fetch_state_t state, state_nxt;
   logic         pc_load;
   logic         pc_inc;
   logic         ir_load;
   logic         ir_clr;

   pc_counter #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst      (rst),
      .inc      (pc_inc),
      .load     (pc_load),
      .load_val (redirect_pc),
      .pc       (pc_out)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= BOOT;
      else     state <= state_nxt;
   end

   // Next state and datapath controls; redirect beats fetch_en beats advance.
   always_comb begin
      state_nxt = state;
      pc_load   = 1'b0;
      pc_inc    = 1'b0;
      ir_load   = 1'b0;
      ir_clr    = 1'b0;
      case (state)
         BOOT: begin
            pc_load   = redirect_valid;
            state_nxt = fetch_en ? RUN : STOP;
         end
         RUN, STOP: begin
            state_nxt = fetch_en ? RUN : STOP;
            if (redirect_valid) begin
               pc_load = 1'b1;
               ir_clr  = 1'b1;
            end else if (state == RUN && fetch_en && (!ir_valid || ir_ready)) begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
            end else if (ir_valid && ir_ready) begin
               ir_clr  = 1'b1;
            end
         end
         default: state_nxt = BOOT;
      endcase
   end

   // Instruction register capture and handshake completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_out   <= NOP_INSTR;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
      end else if (ir_load) begin
         ir_out   <= rom_data;
         ir_pc    <= pc_out;
         ir_valid <= 1'b1;
      end else if (ir_clr) begin
         ir_valid <= 1'b0;
      end
   end

`ifdef FETCH_COUNT_EN
   logic [CNT_W-1:0] count_q;

   // Count every IR load; wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          count_q <= '0;
      else if (ir_load) count_q <= count_q + CNT_W'(1);
   end

   assign fetch_count = count_q;
`else
   assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// against a cycle-level behavioural model of the fetch stage.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        fetch_en;
   logic [7:0]  pc_out;
   logic [15:0] rom_data;
   logic [15:0] ir_out;
   logic [7:0]  ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic [15:0] fetch_count;

   logic [15:0] rom [256];

   int errors = 0;
   int checks = 0;

   // model state
   bit          m_boot;
   bit          m_run;
   logic [7:0]  m_pc;
   logic [15:0] m_ir;
   logic [7:0]  m_irpc;
   bit          m_v;
   logic [15:0] m_cnt;

   fetch_unit #(.RESET_PC(8'h00)) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .pc_out         (pc_out),
      .rom_data       (rom_data),
      .ir_out         (ir_out),
      .ir_pc          (ir_pc),
      .ir_valid       (ir_valid),
      .ir_ready       (ir_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_count    (fetch_count)
   );

   assign rom_data = rom[pc_out];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_count();
`ifdef FETCH_COUNT_EN
      return m_cnt;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic model_reset();
      m_boot = 1'b1;
      m_run  = 1'b0;
      m_pc   = 8'h00;
      m_ir   = 16'h0000;
      m_irpc = 8'h00;
      m_v    = 1'b0;
      m_cnt  = 16'h0000;
   endtask

   // One clock edge of fetch behaviour, from the current inputs.
   task automatic model_step();
      if (m_boot) begin
         if (redirect_valid) m_pc = redirect_pc;
         m_boot = 1'b0;
         m_run  = fetch_en;
      end else begin
         if (redirect_valid) begin
            m_pc = redirect_pc;
            m_v  = 1'b0;
         end else if (m_run && fetch_en && (!m_v || ir_ready)) begin
            m_ir   = rom[m_pc];
            m_irpc = m_pc;
            m_v    = 1'b1;
            m_pc   = m_pc + 8'd1;
            m_cnt  = m_cnt + 16'd1;
         end else if (m_v && ir_ready) begin
            m_v = 1'b0;
         end
         m_run = fetch_en;
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_pc"},    32'(pc_out),      32'h00);
      chk({tag, "_ir"},    32'(ir_out),      32'h0000);
      chk({tag, "_irpc"},  32'(ir_pc),       32'h00);
      chk({tag, "_valid"}, 32'(ir_valid),    32'h0);
      chk({tag, "_count"}, 32'(fetch_count), 32'h0000);
   endtask

   task automatic cycle(input logic fe, input logic rdy, input logic rv, input logic [7:0] rpc);
      fetch_en       = fe;
      ir_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clk);
      model_step();
      #1;
      chk("pc",    32'(pc_out),      32'(m_pc));
      chk("valid", 32'(ir_valid),    32'(m_v));
      chk("ir",    32'(ir_out),      32'(m_ir));
      chk("irpc",  32'(ir_pc),       32'(m_irpc));
      chk("count", 32'(fetch_count), 32'(exp_count()));
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [7:0] frozen_pc;
      logic [15:0] frozen_cnt;

      for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
      rom[0] = 16'hD000;
      rom[1] = 16'hAA09;

      rst = 1'b1; fetch_en = 1'b0; ir_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset("por");

      // first instruction two edges after release
      fetch_en = 1'b1; ir_ready = 1'b1;
      release_reset();
      cycle(1, 1, 0, 0);
      chk("boot_valid", 32'(ir_valid), 32'h0);
      cycle(1, 1, 0, 0);
      chk("first_ir",   32'(ir_out),   32'hD000);
      chk("first_irpc", 32'(ir_pc),    32'h00);
      chk("first_pc",   32'(pc_out),   32'h01);
      cycle(1, 1, 0, 0);
      chk("second_ir",   32'(ir_out), 32'hAA09);
      chk("second_irpc", 32'(ir_pc),  32'h01);

      // decode stall for 3 cycles
      repeat (3) cycle(1, 0, 0, 0);
      chk("stall_irpc", 32'(ir_pc), 32'h01);
      cycle(1, 1, 0, 0);
      chk("unstall_irpc", 32'(ir_pc), 32'h02);

      // redirect to 0 while pc=5
      for (int k = 0; k < 20 && m_pc != 8'h05; k++) cycle(1, 1, 0, 0);
      chk("reach_pc5", 32'(pc_out), 32'h05);
      cycle(1, 1, 1, 8'h00);
      chk("redir_valid", 32'(ir_valid), 32'h0);
      chk("redir_pc",    32'(pc_out),   32'h00);
      cycle(1, 1, 0, 0);
      chk("redir_ir",   32'(ir_out), 32'hD000);
      chk("redir_irpc", 32'(ir_pc),  32'h00);

      // PC wrap
      cycle(1, 1, 1, 8'hFE);
      cycle(1, 1, 0, 0);
      cycle(1, 1, 0, 0);
      chk("wrap_ff", 32'(ir_pc), 32'hFF);
      cycle(1, 1, 0, 0);
      chk("wrap_00", 32'(ir_pc), 32'h00);

      // fetch_en low for 4 cycles with a pending IR
      cycle(1, 0, 0, 0);
      frozen_pc  = pc_out;
      frozen_cnt = fetch_count;
      cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0);
      chk("stop_pc",    32'(pc_out),      32'(frozen_pc));
      chk("stop_count", 32'(fetch_count), 32'(frozen_cnt));
      chk("stop_drain", 32'(ir_valid),    32'h0);
      cycle(1, 1, 0, 0);
      cycle(1, 1, 0, 0);
      chk("resume_irpc", 32'(ir_pc), 32'(frozen_pc));

      // asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      check_reset("async");
      model_reset();
      release_reset();

      // 10 loads, redirect, 2 loads
      cycle(1, 1, 0, 0);
      repeat (10) cycle(1, 1, 0, 0);
      cycle(1, 1, 1, 8'h40);
      repeat (2) cycle(1, 1, 0, 0);
`ifdef FETCH_COUNT_EN
      chk("count12", 32'(fetch_count), 32'd12);
`else
      chk("count_off", 32'(fetch_count), 32'd0);
`endif

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         cycle(1'($urandom_range(0, 9) != 0),
               1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 15) == 0),
               8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
